// File: rtl/hamdec_sched_if.sv
// rtl/hamdec_sched_if.sv - request/response/counter bundle for hamdec_sched
// Ports (signals):
//   req_valid[NREQ], req_cw[9*NREQ]  requester codewords, requester i owns [9i+8:9i]
//   req_ready[NREQ]                  one-hot accept strobe
//   rsp_valid, rsp_ready             response handshake
//   rsp_data, rsp_syn, rsp_corr,
//   rsp_bad, rsp_id                  decoded word, syndrome, status, originating requester
//   cnt_clr, cnt_corr, cnt_bad       error counter clear and saturating counts
// Modports: slave = scheduler side, master = requesters/consumer side.

interface hamdec_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [9*NREQ-1:0] req_cw;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [4:0]        rsp_data;
  logic [3:0]        rsp_syn;
  logic              rsp_corr;
  logic              rsp_bad;
  logic [IDW-1:0]    rsp_id;
  logic              cnt_clr;
  logic [CNTW-1:0]   cnt_corr;
  logic [CNTW-1:0]   cnt_bad;

  modport slave (
    input  req_valid, req_cw, rsp_ready, cnt_clr,
    output req_ready, rsp_valid, rsp_data, rsp_syn, rsp_corr, rsp_bad, rsp_id,
           cnt_corr, cnt_bad
  );

  modport master (
    output req_valid, req_cw, rsp_ready, cnt_clr,
    input  req_ready, rsp_valid, rsp_data, rsp_syn, rsp_corr, rsp_bad, rsp_id,
           cnt_corr, cnt_bad
  );
endinterface

// File: rtl/hamdec_sched.sv
// rtl/hamdec_sched.sv - round-robin scheduler sharing one Hamming(9,5) decoder
// hamdec95:     cw[9] in (bit 0 = position 1) -> corrected data[5] = {p9,p7,p6,p5,p3}
// hamdec_sched: clk, rst (sync, active-high), bus (hamdec_sched_if.slave):
//   arbitrates req_valid round-robin, decodes the winner's codeword in one
//   cycle, returns data/syndrome/status tagged with rsp_id, and keeps
//   saturating counts of corrected and uncorrectable responses.

module hamdec95 (
  input  logic [8:0] cw,
  output logic [4:0] data
);
  logic [3:0] syn;
  logic [8:0] fixed;

  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    syn[3] = cw[7] ^ cw[8];
    fixed  = cw;
    // Syndromes 10..15 point outside the word, so nothing is flipped.
    for (int p = 1; p <= 9; p++) begin
      if (syn == 4'(p)) fixed[p-1] = ~cw[p-1];
    end
    data = {fixed[8], fixed[6], fixed[5], fixed[4], fixed[2]};
  end
endmodule

module hamdec_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input logic         clk,
  input logic         rst,
  hamdec_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, id_q, win_idx;
  logic            win_found;
  logic [8:0]      win_cw, cw_q;
  logic [4:0]      dec_data, data_q;
  logic [3:0]      syn, syn_q;
  logic            corr_q, bad_q, hs;
  logic [CNTW-1:0] cnt_corr_q, cnt_bad_q;
  logic [NREQ-1:0] ready;
  int              scan_idx;

  hamdec95 a_hamdec (
    .cw   (cw_q),
    .data (dec_data)
  );

  // Local syndrome of the latched word; feeds status only.
  always_comb begin
    syn[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6] ^ cw_q[8];
    syn[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6];
    syn[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];
    syn[3] = cw_q[7] ^ cw_q[8];
  end

  // Winner = first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_cw    = '0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!win_found && bus.req_valid[IDW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(scan_idx);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_cw = bus.req_cw[9*i +: 9];
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = '0;
    hs      = (state_q == RESP) && bus.rsp_ready;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ready[win_idx] = 1'b1;
          state_d        = DECODE;
        end
      end
      DECODE:  state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      cw_q       <= '0;
      data_q     <= '0;
      syn_q      <= '0;
      corr_q     <= 1'b0;
      bad_q      <= 1'b0;
      cnt_corr_q <= '0;
      cnt_bad_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_found) begin
        cw_q <= win_cw;
        id_q <= win_idx;
      end
      if (state_q == DECODE) begin
        data_q <= dec_data;
        syn_q  <= syn;
        corr_q <= (syn != 4'd0) && (syn <= 4'd9);
        bad_q  <= (syn >= 4'd10);
      end
      if (hs) ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
      // Clear wins over a same-cycle increment.
      if (bus.cnt_clr) begin
        cnt_corr_q <= '0;
        cnt_bad_q  <= '0;
      end else if (hs) begin
        if (corr_q && cnt_corr_q != '1) cnt_corr_q <= cnt_corr_q + 1'b1;
        if (bad_q && cnt_bad_q != '1)   cnt_bad_q  <= cnt_bad_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_syn   = syn_q;
  assign bus.rsp_corr  = corr_q;
  assign bus.rsp_bad   = bad_q;
  assign bus.rsp_id    = id_q;
  assign bus.cnt_corr  = cnt_corr_q;
  assign bus.cnt_bad   = cnt_bad_q;
endmodule
